// File: rtl/axis_rr_if.sv
// Stream bundle between NUM_INPUTS requesters and one shared sink.
// The slave modport is the arbiter's view; master is the environment's view.
interface axis_rr_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 4
);
   logic [NUM_INPUTS*DATA_WIDTH-1:0] idata;
   logic [NUM_INPUTS-1:0]            ivalid;
   logic [NUM_INPUTS-1:0]            ilast;
   logic [NUM_INPUTS-1:0]            iready;
   logic [DATA_WIDTH-1:0]            odata;
   logic                             olast;
   logic                             ovalid;
   logic                             oready;

   modport slave (
      input  idata, ivalid, ilast, oready,
      output iready, odata, olast, ovalid
   );

   modport master (
      output idata, ivalid, ilast, oready,
      input  iready, odata, olast, ovalid
   );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet/burst round-robin arbiter sharing one AXI-stream sink between
// NUM_INPUTS requesters; the data path is combinational from the owner.
//
// state | meaning
// IDLE  | no owner; pick next requester after grant, one bubble per grant
// BUSY  | grant owns the sink until an ilast beat or MAX_BURST beats
module axis_rr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 4,
   parameter int MAX_BURST  = 16,
   localparam int GW = $clog2(NUM_INPUTS),
   localparam int CW = $clog2(MAX_BURST + 1)
) (
   input  logic          clock,
   input  logic          resetn,
   axis_rr_if.slave      bus,
   output logic [GW-1:0] grant,
   output logic          busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          pick_found;
   logic [GW-1:0] pick;
   logic          accept;
   logic          burst_end;
   int            idx;

   assign busy      = (state == BUSY);
   assign accept    = busy && bus.ivalid[grant] && bus.oready;
   assign burst_end = bus.ilast[grant] || (count == CW'(MAX_BURST - 1));

   // Scan starts just after the last owner so every requester gets its turn.
   always_comb begin
      pick_found = 1'b0;
      pick       = grant;
      idx        = 0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         idx = int'(grant) + k;
         if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
         if (!pick_found && bus.ivalid[GW'(idx)]) begin
            pick_found = 1'b1;
            pick       = GW'(idx);
         end
      end
   end

   always_comb begin
      bus.odata  = '0;
      bus.olast  = 1'b0;
      bus.ovalid = 1'b0;
      bus.iready = '0;
      if (busy) begin
         bus.odata         = bus.idata[grant*DATA_WIDTH +: DATA_WIDTH];
         bus.olast         = bus.ilast[grant];
         bus.ovalid        = bus.ivalid[grant];
         bus.iready[grant] = bus.oready;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         grant <= GW'(NUM_INPUTS - 1);
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state <= BUSY;
                  grant <= pick;
                  count <= '0;
               end
            end
            BUSY: begin
               if (accept) begin
                  count <= count + 1'b1;
                  if (burst_end) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
